sega_joy_scanner: RTL

Two-port Sega joystick scanner for the Multicore 2 arcade tops. It drives the shared DB9 select line (pin 7) through the Mega Drive multiplex sequence and samples both ports at fixed points in that sequence. It detects 3-button, 6-button and Master System pads and publishes stable 12-bit active-low button words per port. It replaces ad-hoc scanning clocked from video sync: it runs from the system clock with an internal step divider, and the core's input mapping consumes its outputs.

---
 rtl/sega_joy_pkg.sv | 43 ++++
 rtl/sega_joy_scanner_if.sv | 11 +
 rtl/sega_joy_port_capture.sv | 60 ++++++
 rtl/sega_joy_scanner.sv | 120 ++++++++++++
 4 files changed

// File: rtl/sega_joy_pkg.sv
// Shared types and constants for the two-port Sega joystick scanner.
// SEGA_JOY_SIX_BUTTON_EN selects the full 8-step sequence; undefined gives the 2-step 3-button scan.
package sega_joy_pkg;

  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, IDLE
  } state_t;

  // Bit positions in the published MXYZ SACB RLDU button word.
  localparam int JOY_UP    = 0;
  localparam int JOY_DOWN  = 1;
  localparam int JOY_LEFT  = 2;
  localparam int JOY_RIGHT = 3;
  localparam int JOY_B     = 4;
  localparam int JOY_C     = 5;
  localparam int JOY_A     = 6;
  localparam int JOY_START = 7;
  localparam int JOY_Z     = 8;
  localparam int JOY_Y     = 9;
  localparam int JOY_X     = 10;
  localparam int JOY_MODE  = 11;

  // Raw DB9 pin positions within the 6-bit pin vector.
  localparam int PIN_P6 = 4;
  localparam int PIN_P9 = 5;

`ifdef SEGA_JOY_SIX_BUTTON_EN
  localparam int     NUM_STEPS  = 8;
  localparam state_t LAST_STATE = S7;
`else
  localparam int     NUM_STEPS  = 2;
  localparam state_t LAST_STATE = S1;
`endif

  // Select line level for a given sequence state (low on odd steps).
  function automatic logic p7_level(state_t s);
    case (s)
      S1, S3, S5, S7: return 1'b0;
      default:        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sega_joy_scanner_if.sv
// One joystick port: raw DB9 pins in, debounced-by-frame button word and six flag out.
// Shared by both SEGA_JOY_SIX_BUTTON_EN builds; six stays 0 when the macro is undefined.
interface sega_joy_scanner_if;
  logic [5:0]  pins;     // active low {p9, p6, right, left, down, up}
  logic [11:0] buttons;  // active low MXYZ SACB RLDU, updated once per frame
  logic        six;      // pad identified as 6-button in the last frame

  // master: the pad side driving pins; slave: the scanner capturing them.
  modport master (output pins, input buttons, input six);
  modport slave  (input pins, output buttons, output six);
endinterface

// File: rtl/sega_joy_port_capture.sv
// Per-port shadow capture: MD/MS decision, 6-button detection and frame-atomic publish.
// Extra-button capture (S5/S6) exists only when SEGA_JOY_SIX_BUTTON_EN is defined.
module sega_joy_port_capture
  import sega_joy_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  state_t             state,
  input  logic               step_end,
  sega_joy_scanner_if.slave  port
);

  logic [11:0] shadow_q, shadow_d;
  logic        six_q, six_d;
  logic [11:0] buttons_q;
  logic        six_out_q;
  logic        md_pad;
  logic        publish;

  // A Mega Drive pad pulls left and right low while select is low; a Master System pad cannot.
  assign md_pad  = ~port.pins[JOY_LEFT] & ~port.pins[JOY_RIGHT];
  assign publish = step_end && (state == LAST_STATE);

  always_comb begin
    shadow_d = shadow_q;
    six_d    = six_q;
    if (step_end) begin
      case (state)
        S0: shadow_d[JOY_C:JOY_UP] = port.pins;
        S1: shadow_d[JOY_START:JOY_A] = md_pad ? port.pins[PIN_P9:PIN_P6] : 2'b11;
`ifdef SEGA_JOY_SIX_BUTTON_EN
        S5: six_d = (port.pins[JOY_RIGHT:JOY_UP] == 4'h0);
        S6: shadow_d[JOY_MODE:JOY_Z] = six_q ? port.pins[JOY_RIGHT:JOY_UP] : 4'hF;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q  <= 12'hFFF;
      six_q     <= 1'b0;
      buttons_q <= 12'hFFF;
      six_out_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      six_q    <= six_d;
      // Publish on the same edge as the last capture so the word is never half old, half new.
      if (publish) begin
        buttons_q <= shadow_d;
        six_out_q <= six_q;
      end
    end
  end

  assign port.buttons = buttons_q;
  assign port.six     = six_out_q;

endmodule

// File: rtl/sega_joy_scanner.sv
// Two-port Sega DB9 scanner: step divider, select-line sequencer and two port captures.
// Define SEGA_JOY_SIX_BUTTON_EN for the S0..S7 six-button sequence; otherwise S0, S1, IDLE.
module sega_joy_scanner
  import sega_joy_pkg::*;
#(
  parameter int STEP_DIV   = 256,
  parameter int IDLE_STEPS = 160
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic [5:0]  joy1_i,
  input  logic [5:0]  joy2_i,
  output logic        joy_p7_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        joy1_six_o,
  output logic        joy2_six_o,
  output logic        frame_o
);

  localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int IDLE_W = (IDLE_STEPS > 1) ? $clog2(IDLE_STEPS) : 1;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                p7_q;
  logic                frame_q, frame_d;
  logic                step_end;

  // Sampling happens only on the terminal count, giving each phase STEP_DIV-1 settling cycles.
  assign step_end = (div_q == DIV_W'(STEP_DIV - 1));
  assign div_d    = step_end ? '0 : div_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    frame_d = 1'b0;
    if (step_end) begin
      case (state_q)
`ifdef SEGA_JOY_SIX_BUTTON_EN
        S0: state_d = S1;
        S1: state_d = S2;
        S2: state_d = S3;
        S3: state_d = S4;
        S4: state_d = S5;
        S5: state_d = S6;
        S6: state_d = S7;
        S7: begin
          state_d = IDLE;
          frame_d = 1'b1;
        end
`else
        S0: state_d = S1;
        S1: begin
          state_d = IDLE;
          frame_d = 1'b1;
        end
`endif
        IDLE: begin
          // Long high idle lets 6-button pads time out their internal step counter.
          if (idle_q == IDLE_W'(IDLE_STEPS - 1)) begin
            state_d = S0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      state_q <= S0;
      div_q   <= '0;
      idle_q  <= '0;
      p7_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idle_q  <= idle_d;
      p7_q    <= p7_level(state_d);
      frame_q <= frame_d;
    end
  end

  assign joy_p7_o = p7_q;
  assign frame_o  = frame_q;

  sega_joy_scanner_if port1 ();
  sega_joy_scanner_if port2 ();

  assign port1.pins = joy1_i;
  assign port2.pins = joy2_i;

  sega_joy_port_capture u_cap1 (
    .clk      (clk_i),
    .rst_n    (res_n_i),
    .state    (state_q),
    .step_end (step_end),
    .port     (port1)
  );

  sega_joy_port_capture u_cap2 (
    .clk      (clk_i),
    .rst_n    (res_n_i),
    .state    (state_q),
    .step_end (step_end),
    .port     (port2)
  );

  assign joy1_o     = port1.buttons;
  assign joy2_o     = port2.buttons;
  assign joy1_six_o = port1.six;
  assign joy2_six_o = port2.six;

endmodule
